bloom_cfg_ctrl: RTL
===================

// Module: bloom_cfg_ctrl
// PURPOSE
//  Configuration sequencer for the bloom filter match engine. Host loads a new
//  64-bit bloom signature into a shadow register as 16-bit words, then requests commit.
//  Block tracks packet framing (in_wr/in_ctrl) and swaps shadow->active only between
//  packets, so no packet is checked against a mix of old and new signatures.
//  Drives the filter's bloom_array_reg input; snapshots the filter's matches_count at swap.
// PARAMETERS
//  ARRAY_W      64      bloom array width; must equal NUM_WORDS*WORD_W
//  WORD_W       16      host write word width
//  NUM_WORDS    4       shadow words; cfg_addr width = clog2(NUM_WORDS) = 2
//  CNT_W        32      match counter / snapshot width
//  RESET_ARRAY  64'h0   reset value of shadow and active arrays
//  TIMEOUT      4096    forced-commit limit in cycles (used only with BLOOM_CFG_FORCE_EN)
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-high reset
//  in_wr            in   1        datapath word valid (same bus the filter sees)
//  in_ctrl          in   8        datapath control byte; !=0 marks header/boundary words
//  cfg_wr_en        in   1        host shadow-word write strobe
//  cfg_addr         in   2        shadow word index; word k = bits [k*WORD_W +: WORD_W]
//  cfg_wr_data      in   WORD_W   shadow write data
//  cfg_commit       in   1        one-cycle commit request
//  matches_count    in   CNT_W    running match count from the filter
//  bloom_array_reg  out  ARRAY_W  active signature to the filter
//  cfg_busy         out  1        commit pending, waiting for a packet boundary
//  cfg_ack          out  1        one-cycle pulse: swap took effect this cycle
//  cfg_err          out  1        one-cycle pulse: write/commit dropped while busy
//  array_version    out  8        increments per swap, wraps 255->0
//  match_snapshot   out  CNT_W    matches_count sampled at the swap edge
//  in_pkt           out  1        framing tracker is not IDLE
// BEHAVIOUR
//  Reset (sync): shadow=active=RESET_ARRAY; cfg_busy=cfg_ack=cfg_err=0; array_version=0;
//   match_snapshot=0; in_pkt=0; tracker=IDLE; pending cleared. A reset mid-packet or
//   mid-pending wins over everything and discards the pending commit.
//  Tracker FSM, advances only when in_wr=1:
//   IDLE -> HDR when in_ctrl!=0. HDR -> PAY when in_ctrl==0. PAY -> IDLE when in_ctrl!=0
//   (end word). All other cases hold state.
//  safe = (state==IDLE) && !(in_wr && in_ctrl!=0). A start-of-packet word blocks the swap.
//  Shadow write: cfg_wr_en && !cfg_busy writes word cfg_addr on the next edge.
//   If cfg_busy, the write is dropped and cfg_err pulses on the next cycle.
//  Commit, cfg_commit at cycle t with !cfg_busy:
//   - If safe at t: active<=shadow at the t edge; visible in t+1; cfg_ack=1 in t+1.
//     Same-cycle cfg_wr_en is included: its new word is merged into the value copied.
//   - Otherwise: pending set, cfg_busy=1 from t+1. Swap occurs at the first safe cycle s;
//     active visible s+1, cfg_ack=1 in s+1, cfg_busy=0 in s+1.
//  cfg_commit while cfg_busy: ignored; cfg_err pulses.
//  At every swap edge: array_version<=array_version+1 (mod 256); match_snapshot<=matches_count.
//  Between swaps, bloom_array_reg is stable. The filter's own register adds one cycle,
//   so the new array reaches the filter at s+2. A header word always precedes payload,
//   so this lag is safe.
//  Active never changes while in_pkt=1, except under the forced commit below.
// CONFIGURATION
//  BLOOM_CFG_FORCE_EN defined: a TIMEOUT-cycle counter runs while pending.
//   - Counter clears on swap or reset.
//   - On reaching TIMEOUT-1, the swap is forced regardless of safe. cfg_ack pulses as normal.
//   - Sticky out port cfg_forced (1 bit, reset 0) sets and holds until reset.
//  BLOOM_CFG_FORCE_EN undefined: no counter, no cfg_forced port. Pending waits indefinitely.
// TESTING
//  T1 reset: hold reset 2 cycles -> bloom_array_reg=0, version=0, busy/ack/err=0.
//  T2 idle load: write words 0..3 = 1111,2222,3333,4444 then commit in IDLE
//   -> next cycle bloom_array_reg=64'h4444_3333_2222_1111, cfg_ack=1, version=1.
//  T3 mid-packet commit: commit during PAY -> busy=1, active unchanged; end word (in_ctrl=FF)
//   -> swap the cycle after the first safe cycle, ack once, snapshot=matches_count(e.g. 7).
//  T4 SoP collision: commit in IDLE in the same cycle as in_wr=1, in_ctrl=FF
//   -> no swap, busy=1; swap waits for that packet's end.
//  T5 busy errors: while busy, write word 0=FFFF and re-commit -> cfg_err pulses twice,
//   shadow unchanged, exactly one ack.
//  T6 (FORCE_EN, TIMEOUT=16) commit inside a never-ending PAY -> swap after 16 cycles,
//   cfg_forced=1; reset mid-pending -> busy=0, no ack.

Source files
------------

// File: rtl/bloom_cfg_ctrl.sv
// rtl/bloom_cfg_ctrl.sv - shadow/active bloom signature sequencer with packet-boundary swap
// Optional feature macro: BLOOM_CFG_FORCE_EN (forced swap after TIMEOUT pending cycles, cfg_forced port)
module bloom_cfg_ctrl #(
   parameter int                 ARRAY_W     = 64,
   parameter int                 WORD_W      = 16,
   parameter int                 NUM_WORDS   = 4,
   parameter int                 CNT_W       = 32,
   parameter logic [ARRAY_W-1:0] RESET_ARRAY = '0,
`ifdef BLOOM_CFG_FORCE_EN
   parameter int                 TIMEOUT     = 4096,
`endif
   localparam int                ADDR_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_wr,
   input  logic [7:0]         in_ctrl,
   input  logic               cfg_wr_en,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [WORD_W-1:0]  cfg_wr_data,
   input  logic               cfg_commit,
   input  logic [CNT_W-1:0]   matches_count,
   output logic [ARRAY_W-1:0] bloom_array_reg,
   output logic               cfg_busy,
   output logic               cfg_ack,
   output logic               cfg_err,
   output logic [7:0]         array_version,
   output logic [CNT_W-1:0]   match_snapshot,
   output logic               in_pkt
`ifdef BLOOM_CFG_FORCE_EN
   ,
   output logic               cfg_forced
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_PAY  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [ARRAY_W-1:0] shadow_q, shadow_d;
   logic [ARRAY_W-1:0] active_q, active_d;
   logic               pending_q, pending_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [7:0]         version_q, version_d;
   logic [CNT_W-1:0]   snap_q, snap_d;

   logic ctrl_nz;
   logic safe;
   logic swap;
   logic force_swap;

   assign ctrl_nz = (in_ctrl != 8'h00);
   // A start-of-packet word in IDLE is already part of the next packet.
   assign safe    = (state_q == ST_IDLE) && !(in_wr && ctrl_nz);

`ifdef BLOOM_CFG_FORCE_EN
   localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            forced_q, forced_d;

   assign force_swap = pending_q && (to_cnt_q == TO_W'(TIMEOUT - 1));
   assign cfg_forced = forced_q;

   // Pending-age counter and sticky flag recording that a swap was forced mid-packet.
   always_comb begin
      to_cnt_d = '0;
      if (pending_q && !swap) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
      forced_d = forced_q | (force_swap && !safe);
   end

   // Force-path registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q <= '0;
         forced_q <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         forced_q <= forced_d;
      end
   end
`else
   assign force_swap = 1'b0;
`endif

   // Packet framing tracker: advances only on valid datapath words.
   always_comb begin
      state_d = state_q;
      if (in_wr) begin
         case (state_q)
            ST_IDLE: if (ctrl_nz)  state_d = ST_HDR;
            ST_HDR:  if (!ctrl_nz) state_d = ST_PAY;
            ST_PAY:  if (ctrl_nz)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Shadow writes, commit/pending handling and the shadow->active swap.
   always_comb begin
      shadow_d = shadow_q;
      if (cfg_wr_en && !pending_q) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (cfg_addr == ADDR_W'(k)) begin
               shadow_d[k*WORD_W +: WORD_W] = cfg_wr_data;
            end
         end
      end

      // shadow_d carries any same-cycle write into the copied value.
      swap      = pending_q ? (safe || force_swap) : (cfg_commit && safe);
      active_d  = swap ? shadow_d : active_q;
      pending_d = swap ? 1'b0 : (pending_q || cfg_commit);
      ack_d     = swap;
      err_d     = pending_q && (cfg_wr_en || cfg_commit);
      version_d = swap ? version_q + 8'd1 : version_q;
      snap_d    = swap ? matches_count : snap_q;
   end

   // State registers; reset discards any pending commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shadow_q  <= RESET_ARRAY;
         active_q  <= RESET_ARRAY;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         version_q <= 8'd0;
         snap_q    <= '0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         version_q <= version_d;
         snap_q    <= snap_d;
      end
   end

   assign bloom_array_reg = active_q;
   assign cfg_busy        = pending_q;
   assign cfg_ack         = ack_q;
   assign cfg_err         = err_q;
   assign array_version   = version_q;
   assign match_snapshot  = snap_q;
   assign in_pkt          = (state_q != ST_IDLE);

endmodule
